// File: rtl/iter_arbiter.sv
// iter_arbiter: round-robin arbiter sequencing one shared load/iterate/zero datapath.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   req      - request levels, one bit per requester
//   gnt      - one-hot grant, held from INIT through FIN
//   done     - one-cycle completion pulse to the granted requester (during FIN)
//   err      - one-cycle timeout pulse, coincident with done
//   dp_load  - datapath load strobe (INIT)
//   dp_iter  - datapath iterate enable (ITER while zero flag is low)
//   dp_zero  - datapath termination flag
//   busy     - high whenever the sequencer is not idle
//   iter_cnt - dp_iter cycles counted in the current or last operation
module iter_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_ITER = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] err,
    output logic             dp_load,
    output logic             dp_iter,
    input  logic             dp_zero,
    output logic             busy,
    output logic [CNT_W-1:0] iter_cnt
);
    localparam int PW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, INIT, ITER, FIN} state_t;

    state_t             state, state_nx;
    logic [PW-1:0]      ptr, ptr_nx, gidx;
    logic [N_REQ-1:0]   sel, oh;
    logic [2*N_REQ-1:0] rr, gg;
    logic               last;

    assign dp_load = state == INIT;
    assign dp_iter = (state == ITER) && !dp_zero;
    assign busy    = state != IDLE;
    assign last    = iter_cnt == CNT_W'(MAX_ITER - 1);

    // Rotate requests so the pointer sits at bit 0, pick the lowest set bit,
    // then rotate the one-hot pick back into requester positions.
    always_comb begin
        rr = {req, req} >> ptr;
        oh = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (rr[i]) oh = N_REQ'(1) << i;
        gg  = {oh, oh} << ptr;
        sel = gg[2*N_REQ-1:N_REQ];
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (gnt[i]) gidx = PW'(i);
        ptr_nx = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |req ? INIT : IDLE;
            INIT:    state_nx = ITER;
            ITER:    state_nx = (dp_zero || last) ? FIN : ITER;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt      <= '0;
            done     <= '0;
            err      <= '0;
            iter_cnt <= '0;
        end else begin
            state <= state_nx;
            done  <= '0;
            err   <= '0;
            if (state == IDLE && |req) begin
                gnt      <= sel;
                iter_cnt <= '0;
            end
            if (dp_iter && iter_cnt != CNT_W'(MAX_ITER))
                iter_cnt <= iter_cnt + 1'b1;
            // A zero flag on the final allowed cycle still counts as normal completion.
            if (state == ITER && (dp_zero || last)) begin
                done <= gnt;
                err  <= dp_zero ? '0 : gnt;
            end
            if (state == FIN) begin
                gnt <= '0;
                ptr <= ptr_nx;
            end
        end
    end
endmodule

// File: tb/tb_iter_arbiter.sv
// tb_iter_arbiter: directed self-checking bench for iter_arbiter with a counting datapath model.
module tb_iter_arbiter;
    logic       clk = 0;
    logic       rst_n = 0;
    logic [3:0] req = 0;
    logic [3:0] gnt, done, err;
    logic       dp_load, dp_iter, dp_zero, busy;
    logic [4:0] iter_cnt;
    logic [7:0] dp_cnt = 0;
    logic [7:0] dp_tgt = 0;
    int nc = 0;
    int nf = 0;

    iter_arbiter #(.N_REQ(4), .MAX_ITER(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .done(done), .err(err),
        .dp_load(dp_load), .dp_iter(dp_iter), .dp_zero(dp_zero), .busy(busy),
        .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    // Datapath model: raises zero once it has seen dp_tgt iterations since load.
    always @(posedge clk) dp_cnt <= dp_load ? 8'd0 : dp_iter ? dp_cnt + 8'd1 : dp_cnt;
    assign dp_zero = dp_cnt >= dp_tgt;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 0;
        req = 0;
        step;
        step;
        nc++; if ({gnt, done, err} !== 12'h0) begin nf++; $display("FAIL reset_gnt_done_err got %h exp 000", {gnt, done, err}); end
        nc++; if ({dp_load, dp_iter, busy} !== 3'b000) begin nf++; $display("FAIL reset_strobes got %b exp 000", {dp_load, dp_iter, busy}); end
        nc++; if (iter_cnt !== 5'd0) begin nf++; $display("FAIL reset_iter_cnt got %0d exp 0", iter_cnt); end
        rst_n = 1;
        step;
    endtask

    task automatic test_simultaneous;
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int w;
        dp_tgt = 2;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            w = 0;
            while (gnt == 0 && w < 20) begin step; w++; end
            nc++; if (gnt !== exp_g[g]) begin nf++; $display("FAIL rr_gnt%0d got %b exp %b", g, gnt, exp_g[g]); end
            w = 0;
            while (done == 0 && w < 20) begin step; w++; end
            nc++; if (done !== exp_g[g]) begin nf++; $display("FAIL rr_done%0d got %b exp %b", g, done, exp_g[g]); end
            step;
            if (g == 4) req = 0;
        end
        step;
    endtask

    task automatic test_single;
        int n;
        dp_tgt = 5;
        req = 4'b0010;
        step;
        nc++; if (gnt !== 4'b0010) begin nf++; $display("FAIL single_gnt got %b exp 0010", gnt); end
        nc++; if ({dp_load, dp_iter} !== 2'b10) begin nf++; $display("FAIL single_load got %b exp 10", {dp_load, dp_iter}); end
        req = 0;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            step;
            if (dp_iter && !dp_load) n++;
        end
        nc++; if (n !== 5) begin nf++; $display("FAIL single_iter_cycles got %0d exp 5", n); end
        step;
        nc++; if ({dp_iter, done} !== 5'b0) begin nf++; $display("FAIL single_zero_cycle got %b exp 00000", {dp_iter, done}); end
        step;
        nc++; if (done !== 4'b0010 || err !== 4'b0000) begin nf++; $display("FAIL single_done got %b/%b exp 0010/0000", done, err); end
        nc++; if (iter_cnt !== 5'd5) begin nf++; $display("FAIL single_iter_cnt got %0d exp 5", iter_cnt); end
        step;
        nc++; if ({gnt, done, busy} !== 9'b0) begin nf++; $display("FAIL single_after got %b exp 0", {gnt, done, busy}); end
        nc++; if (iter_cnt !== 5'd5) begin nf++; $display("FAIL single_cnt_hold got %0d exp 5", iter_cnt); end
    endtask

    task automatic test_immediate_zero;
        dp_tgt = 0;
        req = 4'b0001;
        step;
        nc++; if (gnt !== 4'b0001 || iter_cnt !== 5'd0) begin nf++; $display("FAIL imm_gnt got %b/%0d exp 0001/0", gnt, iter_cnt); end
        req = 0;
        step;
        nc++; if (dp_iter !== 1'b0) begin nf++; $display("FAIL imm_iter got %b exp 0", dp_iter); end
        step;
        nc++; if (done !== 4'b0001 || iter_cnt !== 5'd0) begin nf++; $display("FAIL imm_done got %b/%0d exp 0001/0", done, iter_cnt); end
        step;
    endtask

    task automatic test_withdrawal;
        int w;
        dp_tgt = 3;
        req = 4'b0100;
        step;
        nc++; if (gnt !== 4'b0100) begin nf++; $display("FAIL wd_gnt got %b exp 0100", gnt); end
        step;
        req = 4'b1001;
        w = 0;
        while (done == 0 && w < 20) begin step; w++; end
        nc++; if (done !== 4'b0100) begin nf++; $display("FAIL wd_done got %b exp 0100", done); end
        step;
        nc++; if (gnt !== 4'b0000) begin nf++; $display("FAIL wd_idle got %b exp 0000", gnt); end
        step;
        nc++; if (gnt !== 4'b1000) begin nf++; $display("FAIL wd_next got %b exp 1000", gnt); end
        req = 0;
        w = 0;
        while (done == 0 && w < 20) begin step; w++; end
        step;
    endtask

    task automatic test_timeout;
        int n;
        dp_tgt = 8'd255;
        req = 4'b0001;
        step;
        req = 0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            step;
            if (done != 0) break;
            if (dp_iter) n++;
        end
        nc++; if (n !== 16) begin nf++; $display("FAIL to_iter_cycles got %0d exp 16", n); end
        nc++; if (done !== 4'b0001 || err !== 4'b0001) begin nf++; $display("FAIL to_done_err got %b/%b exp 0001/0001", done, err); end
        nc++; if (iter_cnt !== 5'd16) begin nf++; $display("FAIL to_iter_cnt got %0d exp 16", iter_cnt); end
        step;
        nc++; if ({done, err} !== 8'b0) begin nf++; $display("FAIL to_pulse_end got %b exp 0", {done, err}); end
    endtask

    task automatic test_mid_reset;
        dp_tgt = 8'd255;
        req = 4'b0011;
        step;
        nc++; if (gnt !== 4'b0010) begin nf++; $display("FAIL mr_gnt got %b exp 0010", gnt); end
        step;
        step;
        #2 rst_n = 0;
        #1;
        nc++; if ({gnt, busy, dp_iter} !== 6'b0) begin nf++; $display("FAIL mr_async got %b exp 0", {gnt, busy, dp_iter}); end
        step;
        nc++; if ({done, err, iter_cnt} !== 13'b0) begin nf++; $display("FAIL mr_nodone got %h exp 0", {done, err, iter_cnt}); end
        rst_n = 1;
        step;
        nc++; if (gnt !== 4'b0001) begin nf++; $display("FAIL mr_prio got %b exp 0001", gnt); end
        req = 0;
    endtask

    initial begin
        test_reset;
        test_simultaneous;
        test_single;
        test_immediate_zero;
        test_withdrawal;
        test_timeout;
        test_mid_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
    end
endmodule
